// File: rtl/program_memory_if.sv
// Control/handshake bundle between the program loader, the CPU and program_memory.
// Latency: none; this file contains only wires.
// Backpressure: load_ready qualifies load_valid. Optional load_checksum exists only with LOAD_CHECKSUM_EN.
interface program_memory_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              ram_read_en;
    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_address;
    logic              load_start;
    logic              run_start;
    logic              load_valid;
    logic [WIDTH-1:0]  load_data;
    logic              load_ready;
    logic              load_done;
    logic              cpu_run;
`ifdef LOAD_CHECKSUM_EN
    logic [WIDTH-1:0]  load_checksum;
`endif

    // Driver side: loader and CPU.
    modport master (
        output ram_read_en, ram_write_en, ram_address,
        output load_start, run_start, load_valid, load_data,
        input  load_ready, load_done, cpu_run
`ifdef LOAD_CHECKSUM_EN
        , input load_checksum
`endif
    );

    // Memory side.
    modport slave (
        input  ram_read_en, ram_write_en, ram_address,
        input  load_start, run_start, load_valid, load_data,
        output load_ready, load_done, cpu_run
`ifdef LOAD_CHECKSUM_EN
        , output load_checksum
`endif
    );
endinterface

// File: rtl/program_memory.sv
// Program store: a streaming loader fills 2^ADDR_W words, then the CPU port owns the memory. Optional LOAD_CHECKSUM_EN adds load_checksum.
// Latency: one cycle per accepted load byte; CPU reads are combinational (zero cycles) and CPU writes land at the edge.
// Backpressure: load_ready is registered state (high only in LOAD) and never depends on load_valid; the CPU port is ignored outside RUN.
module program_memory #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    program_memory_if.slave    pm,
    // The shared CPU bus stays a plain inout so it resolves as a real tristate pin.
    inout  wire  [WIDTH-1:0]   ram_data
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic accept;
    logic last_byte;
    logic in_run;
    logic cpu_rd;
    logic cpu_wr;

    // A byte is taken whenever LOAD sees load_valid; a coincident load_start still writes the byte.
    assign accept    = (state_q == LOAD) && pm.load_valid;
    assign last_byte = accept && (ptr_q == {ADDR_W{1'b1}});
    assign in_run    = (state_q == RUN);
    // A write takes priority over a read, so the bus is never driven during a CPU write.
    assign cpu_rd    = in_run && pm.ram_read_en && !pm.ram_write_en;
    assign cpu_wr    = in_run && pm.ram_write_en;

    assign ram_data  = cpu_rd ? mem[pm.ram_address] : {WIDTH{1'bz}};

    // State, load pointer and done pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Next state: load_start beats everything, including completion of the final byte.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        if (accept) begin
            ptr_d = ptr_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (pm.load_start) begin
                    state_d = LOAD;
                end else if (pm.run_start) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (!pm.load_start && last_byte) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            RUN: begin
                if (pm.load_start) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pm.load_start) begin
            state_d = LOAD;
            ptr_d   = '0;
        end
    end

    // Outputs are pure functions of registered state.
    always_comb begin
        pm.load_ready = (state_q == LOAD);
        pm.cpu_run    = in_run;
        pm.load_done  = done_q;
    end

    // Memory array: no reset, so contents survive reset and abandoned loads.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[ptr_q] <= pm.load_data;
        end else if (cpu_wr) begin
            mem[pm.ram_address] <= ram_data;
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;

    // Running modulo sum of accepted bytes; a new load_start clears it, and that clear wins over a coincident byte.
    always_comb begin
        csum_d = csum_q;
        if (pm.load_start) begin
            csum_d = '0;
        end else if (accept) begin
            csum_d = csum_q + pm.load_data;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign pm.load_checksum = csum_q;
`endif
endmodule

// File: tb/tb_program_memory.sv
module tb_program_memory;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    program_memory_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) pm ();
    wire  [WIDTH-1:0] ram_data;
    logic             tb_drv_en;
    logic [WIDTH-1:0] tb_drv;
    assign ram_data = tb_drv_en ? tb_drv : {WIDTH{1'bz}};

    program_memory #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pm       (pm),
        .ram_data (ram_data)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] model [DEPTH];
    logic [7:0] pat   [DEPTH];
    logic [7:0] rd_q  [$];
    int tb_ptr;

    typedef struct {
        logic rst_v;
        logic ls;
        logic rs;
        logic e_ready;
        logic e_run;
        logic e_done;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model side of one accepted byte plus the handshake outputs seen right after it.
    task automatic accept(input logic [7:0] d);
        model[tb_ptr] = d;
        tb_ptr = (tb_ptr + 1) % DEPTH;
        if (tb_ptr == 0) begin
            check("done_on_last", pm.load_done, 1);
            check("run_on_last", pm.cpu_run, 1);
            check("ready_after_last", pm.load_ready, 0);
        end else begin
            check("done_mid_load", pm.load_done, 0);
            check("ready_mid_load", pm.load_ready, 1);
        end
    endtask

    task automatic load_seq(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                pm.load_valid = 1'b0;
                tick();
                check("gap_ready", pm.load_ready, 1);
                check("gap_done", pm.load_done, 0);
            end
            pm.load_valid = 1'b1;
            pm.load_data  = pat[i];
            tick();
            accept(pat[i]);
        end
        pm.load_valid = 1'b0;
    endtask

    task automatic start_load();
        pm.load_start = 1'b1;
        tick();
        pm.load_start = 1'b0;
        tb_ptr = 0;
        check("ready_in_load", pm.load_ready, 1);
        check("run_in_load", pm.cpu_run, 0);
    endtask

    // Zero-latency reads: expectation queued at drive time, popped once the bus settles.
    task automatic read_all(input string name);
        for (int a = 0; a < DEPTH; a++) begin
            pm.ram_address = 4'(a);
            pm.ram_read_en = 1'b1;
            rd_q.push_back(model[a]);
            #1;
            check($sformatf("%s[%0d]", name, a), ram_data, rd_q.pop_front());
        end
        pm.ram_read_en = 1'b0;
    endtask

    task automatic bus_idle_check(input string name);
        pm.ram_address = 4'd0;
        pm.ram_read_en = 1'b1;
        tb_drv = 8'h00;
        tb_drv_en = 1'b1;
        #1;
        check(name, ram_data, 8'h00);
        tb_drv_en = 1'b0;
        pm.ram_read_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        pm.ram_read_en  = 1'b0;
        pm.ram_write_en = 1'b0;
        pm.ram_address  = '0;
        pm.load_start   = 1'b0;
        pm.run_start    = 1'b0;
        pm.load_valid   = 1'b0;
        pm.load_data    = '0;
        tb_drv_en       = 1'b0;
        tb_drv          = '0;
        tb_ptr          = 0;

        // Reset state
        tick();
        tick();
        check("rst_ready", pm.load_ready, 0);
        check("rst_done", pm.load_done, 0);
        check("rst_run", pm.cpu_run, 0);
`ifdef LOAD_CHECKSUM_EN
        check("rst_csum", pm.load_checksum, 0);
`endif
        bus_idle_check("rst_bus_hiz");

        // FSM control table
        for (int i = 0; i < 11; i++) begin
            rst           = tbl[i].rst_v;
            pm.load_start = tbl[i].ls;
            pm.run_start  = tbl[i].rs;
            tick();
            pm.load_start = 1'b0;
            pm.run_start  = 1'b0;
            check($sformatf("tbl%0d_ready", i), pm.load_ready, tbl[i].e_ready);
            check($sformatf("tbl%0d_run", i), pm.cpu_run, tbl[i].e_run);
            check($sformatf("tbl%0d_done", i), pm.load_done, tbl[i].e_done);
        end

        // Full load with valid held high, pattern 0x21, 0x12, ...
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'h21 ^ 8'(i * 8'h33);
        start_load();
        bus_idle_check("load_bus_hiz");
        load_seq(16, 1'b0);
        tick();
        check("done_drops", pm.load_done, 0);
        check("run_holds", pm.cpu_run, 1);
`ifdef LOAD_CHECKSUM_EN
        begin
            logic [7:0] s;
            s = 8'h00;
            for (int i = 0; i < DEPTH; i++) s = s + pat[i];
            check("csum_pattern", pm.load_checksum, s);
        end
`endif
        read_all("rd_load1");

        // CPU write, read back, then simultaneous read+write leaves the bus to the writer
        pm.ram_address  = 4'hE;
        pm.ram_write_en = 1'b1;
        tb_drv          = 8'h5A;
        tb_drv_en       = 1'b1;
        tick();
        model[14] = 8'h5A;
        pm.ram_write_en = 1'b0;
        tb_drv_en       = 1'b0;
        pm.ram_read_en  = 1'b1;
        rd_q.push_back(model[14]);
        #1;
        check("rd_after_wr", ram_data, rd_q.pop_front());
        pm.ram_address  = 4'h3;
        pm.ram_write_en = 1'b1;
        tb_drv          = 8'h3C;
        tb_drv_en       = 1'b1;
        #1;
        check("both_en_bus", ram_data, 8'h3C);
        tick();
        model[3] = 8'h3C;
        pm.ram_write_en = 1'b0;
        pm.ram_read_en  = 1'b0;
        tb_drv_en       = 1'b0;
        read_all("rd_cpu_wr");

        // Load with load_valid toggling every other cycle
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'hA0 + 8'(i);
        start_load();
        load_seq(16, 1'b1);
        tick();
        check("gap_done_drops", pm.load_done, 0);
        read_all("rd_gap");

        // Reset after 7 bytes; CPU writes ignored in IDLE
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'h40 + 8'(i);
        start_load();
        load_seq(7, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_run", pm.cpu_run, 0);
        check("midrst_ready", pm.load_ready, 0);
        check("midrst_done", pm.load_done, 0);
        tick();
        rst = 1'b1;
        pm.ram_address  = 4'hF;
        pm.ram_write_en = 1'b1;
        tb_drv          = 8'hEE;
        tb_drv_en       = 1'b1;
        tick();
        pm.ram_write_en = 1'b0;
        tb_drv_en       = 1'b0;
        check("idle_run", pm.cpu_run, 0);
        pm.run_start = 1'b1;
        tick();
        pm.run_start = 1'b0;
        check("runstart_run", pm.cpu_run, 1);
        read_all("rd_midrst");

        // Restart on the 10th byte, then 16 fresh bytes
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'h70 + 8'(i);
        start_load();
        load_seq(9, 1'b0);
        pm.load_valid = 1'b1;
        pm.load_data  = 8'h99;
        pm.load_start = 1'b1;
        tick();
        pm.load_start = 1'b0;
        pm.load_valid = 1'b0;
        model[9] = 8'h99;
        tb_ptr = 0;
        check("restart_done", pm.load_done, 0);
        check("restart_ready", pm.load_ready, 1);
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'hC0 + 8'(i);
        load_seq(16, 1'b0);
        tick();
        read_all("rd_restart");

        // Restart coinciding with the final byte: byte written, no done
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'h10 + 8'(i);
        start_load();
        load_seq(15, 1'b0);
        pm.load_valid = 1'b1;
        pm.load_data  = 8'hF5;
        pm.load_start = 1'b1;
        tick();
        pm.load_start = 1'b0;
        pm.load_valid = 1'b0;
        model[15] = 8'hF5;
        tb_ptr = 0;
        check("last_restart_done", pm.load_done, 0);
        check("last_restart_ready", pm.load_ready, 1);
        check("last_restart_run", pm.cpu_run, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pm.run_start = 1'b1;
        tick();
        pm.run_start = 1'b0;
        read_all("rd_last_restart");

`ifdef LOAD_CHECKSUM_EN
        // Checksum of sixteen 0x11 bytes, then cleared by the next load_start
        for (int i = 0; i < DEPTH; i++) pat[i] = 8'h11;
        start_load();
        check("csum_cleared_start", pm.load_checksum, 0);
        load_seq(16, 1'b0);
        check("csum_0x11", pm.load_checksum, 8'h10);
        tick();
        check("csum_held", pm.load_checksum, 8'h10);
        start_load();
        check("csum_cleared", pm.load_checksum, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
